// File: rtl/fp_fmt_pkg.sv
// Shared constants and state encoding for the decimal ASCII formatter.
package fp_fmt_pkg;

  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_E     = 8'h45;
  localparam logic [7:0] CH_ZERO  = 8'h30;

  localparam int unsigned MANT_DIG_DEF = 8;
  localparam int unsigned EXP_DIG_DEF  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_SIGN,
    ST_MDIG,
    ST_ECH,
    ST_ESIGN,
    ST_EDIG
  } fmt_state_e;

endpackage

// File: rtl/bcd_dd_seq.sv
// Sequential double-dabble: one binary bit per cycle, MSB first.
// The BCD result holds after done until the next start.
module bcd_dd_seq #(
  parameter int unsigned W   = 24,
  parameter int unsigned DIG = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [W-1:0]     bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [4*DIG-1:0] bcd_o
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]     sh_q;
  logic [4*DIG-1:0] bcd_q, adj;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;

  always_comb begin
    adj = bcd_q;
    for (int unsigned i = 0; i < DIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      sh_q   <= bin_i;
      bcd_q  <= '0;
      cnt_q  <= CW'(W);
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      sh_q  <= sh_q << 1;
      bcd_q <= {adj[4*DIG-2:0], sh_q[W-1]};
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/fp_dec_ascii_fmt.sv
// Serialises a decoded (sign, significand, exponent sign, exponent) record
// as "<sign><digits>E<esign><edigits>" over a valid/ready byte stream.
module fp_dec_ascii_fmt
  import fp_fmt_pkg::*;
#(
  parameter int unsigned MANT_W   = 24,
  parameter int unsigned EXP_W    = 8,
  parameter int unsigned MANT_DIG = MANT_DIG_DEF,
  parameter int unsigned EXP_DIG  = EXP_DIG_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_sign,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [7:0]        in_esign,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last
);

  localparam int unsigned DIG_W = $clog2((MANT_DIG > EXP_DIG) ? MANT_DIG : EXP_DIG);

  fmt_state_e          state_q, state_d;
  logic [DIG_W-1:0]    dig_q, dig_d, m_top, e_top;
  logic [7:0]          sign_q, sign_d, esign_q, esign_d;
  logic [4*MANT_DIG-1:0] m_bcd;
  logic [4*EXP_DIG-1:0]  e_bcd;
  logic [3:0]          m_dig, e_dig;
  logic                m_busy, m_done, e_busy, e_done, start;

  assign start = in_valid & in_ready;

  bcd_dd_seq #(.W(MANT_W), .DIG(MANT_DIG)) u_mant (
    .clk(clk), .rst(rst), .start_i(start), .bin_i(in_mant),
    .busy_o(m_busy), .done_o(m_done), .bcd_o(m_bcd)
  );

  bcd_dd_seq #(.W(EXP_W), .DIG(EXP_DIG)) u_exp (
    .clk(clk), .rst(rst), .start_i(start), .bin_i(in_exp),
    .busy_o(e_busy), .done_o(e_done), .bcd_o(e_bcd)
  );

  // Highest nonzero digit index (0 for an all-zero value) and current digit pick.
  always_comb begin
    m_top = '0;
    e_top = '0;
    m_dig = '0;
    e_dig = '0;
    for (int unsigned i = 1; i < MANT_DIG; i++)
      if (m_bcd[4*i +: 4] != 4'd0) m_top = DIG_W'(i);
    for (int unsigned i = 1; i < EXP_DIG; i++)
      if (e_bcd[4*i +: 4] != 4'd0) e_top = DIG_W'(i);
    for (int unsigned i = 0; i < MANT_DIG; i++)
      if (dig_q == DIG_W'(i)) m_dig = m_bcd[4*i +: 4];
    for (int unsigned i = 0; i < EXP_DIG; i++)
      if (dig_q == DIG_W'(i)) e_dig = e_bcd[4*i +: 4];
  end

  always_comb begin
    state_d   = state_q;
    dig_d     = dig_q;
    sign_d    = sign_q;
    esign_d   = esign_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_byte  = '0;
    out_last  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = ~(m_busy | e_busy);
        if (in_valid && in_ready) begin
          sign_d  = (in_sign  == CH_MINUS) ? CH_MINUS : CH_PLUS;
          esign_d = (in_esign == CH_MINUS) ? CH_MINUS : CH_PLUS;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        if (m_done && e_done) begin
          dig_d   = m_top;
          state_d = ST_SIGN;
        end
      end
      ST_SIGN: begin
        out_valid = 1'b1;
        out_byte  = sign_q;
        if (out_ready) state_d = ST_MDIG;
      end
      ST_MDIG: begin
        out_valid = 1'b1;
        out_byte  = CH_ZERO + {4'd0, m_dig};
        if (out_ready) begin
          if (dig_q == '0) state_d = ST_ECH;
          else             dig_d   = dig_q - DIG_W'(1);
        end
      end
      ST_ECH: begin
        out_valid = 1'b1;
        out_byte  = CH_E;
        if (out_ready) begin
          dig_d   = e_top;
          state_d = ST_ESIGN;
        end
      end
      ST_ESIGN: begin
        out_valid = 1'b1;
        out_byte  = esign_q;
        if (out_ready) state_d = ST_EDIG;
      end
      ST_EDIG: begin
        out_valid = 1'b1;
        out_byte  = CH_ZERO + {4'd0, e_dig};
        out_last  = (dig_q == '0);
        if (out_ready) begin
          if (dig_q == '0) state_d = ST_IDLE;
          else             dig_d   = dig_q - DIG_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dig_q   <= '0;
      sign_q  <= '0;
      esign_q <= '0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      sign_q  <= sign_d;
      esign_q <= esign_d;
    end
  end

endmodule

// File: tb/tb_fp_dec_ascii_fmt.sv
// Bench for fp_dec_ascii_fmt: string-level reference model, byte scoreboard,
// directed records with literal expectations, backpressure and reset cases.
module tb_fp_dec_ascii_fmt;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [7:0]  in_sign, in_esign;
  logic [23:0] in_mant;
  logic [7:0]  in_exp;
  logic        out_valid, out_ready, out_last;
  logic [7:0]  out_byte;

  always #5 clk = ~clk;

  fp_dec_ascii_fmt #(.MANT_W(24), .EXP_W(8), .MANT_DIG(8), .EXP_DIG(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_mant(in_mant), .in_esign(in_esign), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .out_last(out_last)
  );

  logic [7:0] exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;
  bit  stall_en = 1'b0;
  bit  prev_stall = 1'b0;
  logic [7:0] prev_byte;
  logic       prev_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: the record is just the decimal rendering of the four fields.
  function automatic string model(input logic [7:0] s, input int unsigned m,
                                  input logic [7:0] es, input int unsigned e);
    return $sformatf("%s%0dE%s%0d", (s == 8'h2D) ? "-" : "+", m,
                     (es == 8'h2D) ? "-" : "+", e);
  endfunction

  // Downstream ready: always 1, or pseudo-random when stalling is enabled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = stall_en ? ($urandom_range(0, 2) != 0 ? 1'b0 : 1'b1) : 1'b1;
    end
  end

  // Scoreboard compare on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("valid_held", out_valid, 1);
          if (out_valid) begin
            chk("byte_stable", out_byte, prev_byte);
            chk("last_stable", out_last, prev_last);
          end
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL extra_byte: got %0h, expected no byte at %0t", out_byte, $time);
          end else begin
            chk("byte", out_byte, exp_q[0]);
            chk("last", out_last, (exp_q.size() == 1));
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_byte  = out_byte;
        prev_last  = out_last;
      end
    end
  end

  task automatic start_rec(input logic [7:0] s, input int unsigned m,
                           input logic [7:0] es, input int unsigned e, input string lit);
    string str;
    int    n;
    str = model(s, m, es, e);
    n_cmp++;
    if (str != lit) begin
      n_fail++;
      $display("FAIL model_pin: got %s, expected %s", str, lit);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 60);
    chk("in_ready_before_send", in_ready, 1);
    for (int i = 0; i < lit.len(); i++) exp_q.push_back(lit[i]);
    in_sign  = s;
    in_mant  = 24'(m);
    in_esign = es;
    in_exp   = 8'(e);
    in_valid = 1'b1;
    @(posedge clk);
    // keep offering a different record while busy; it must be ignored
    #1;
    in_sign  = 8'h2D;
    in_mant  = ~24'(m);
    in_esign = 8'h2D;
    in_exp   = ~8'(e);
  endtask

  task automatic wait_first(input bit chk_lat);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
      if (!out_valid) chk("in_ready_conv", in_ready, 0);
    end while (!out_valid && n < 40);
    in_valid = 1'b0;
    chk("first_valid_seen", out_valid, 1);
    if (chk_lat) chk("latency", n, 25);
  endtask

  task automatic finish_rec();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      chk("in_ready_emit", in_ready, 0);
      @(posedge clk);
      #1;
      n++;
    end
    chk("record_done", exp_q.size(), 0);
    chk("in_ready_after", in_ready, 1);
    chk("valid_after", out_valid, 0);
  endtask

  task automatic pulse_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_last", out_last, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0;
    in_sign = '0; in_mant = '0; in_esign = '0; in_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_byte", out_byte, 8'h00);
    chk("reset_out_last", out_last, 0);
    rst = 1'b0;

    start_rec(8'h2D, 1234, 8'h2B, 5, "-1234E+5");
    wait_first(1'b1);
    finish_rec();

    start_rec(8'h2B, 0, 8'h2B, 0, "+0E+0");
    wait_first(1'b1);
    finish_rec();

    start_rec(8'h2D, 16777215, 8'h2D, 255, "-16777215E-255");
    wait_first(1'b1);
    finish_rec();

    stall_en = 1'b1;
    start_rec(8'h2B, 100, 8'h2B, 10, "+100E+10");
    wait_first(1'b1);
    finish_rec();
    start_rec(8'h2D, 10000000, 8'h2B, 100, "-10000000E+100");
    wait_first(1'b0);
    finish_rec();
    stall_en = 1'b0;

    // reset during conversion
    start_rec(8'h2D, 4321, 8'h2D, 77, "-4321E-77");
    repeat (10) @(posedge clk);
    #1;
    pulse_reset();
    start_rec(8'h2B, 7, 8'h2B, 1, "+7E+1");
    wait_first(1'b1);
    finish_rec();

    // reset after three bytes have transferred
    start_rec(8'h2D, 16777215, 8'h2D, 255, "-16777215E-255");
    wait_first(1'b0);
    for (int n = 0; n < 20 && exp_q.size() > 11; n++) begin
      @(posedge clk);
      #1;
    end
    chk("three_bytes_sent", exp_q.size(), 11);
    pulse_reset();
    start_rec(8'h2B, 7, 8'h2B, 1, "+7E+1");
    wait_first(1'b1);
    finish_rec();

    start_rec(8'h41, 9, 8'h00, 3, "+9E+3");
    wait_first(1'b1);
    finish_rec();

    start_rec(8'h2B, 5050, 8'h2D, 128, "+5050E-128");
    wait_first(1'b0);
    finish_rec();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
